// File: rtl/huc6280_bus_master.sv
// huc6280_bus_master: CPU-side initiator translating 16-bit logical requests through
// eight MPR bank registers onto the 21-bit physical bus with single-cycle strobes.
module huc6280_bus_master #(
    parameter bit          SLOW_IO   = 1'b1,
    parameter logic [20:0] SLOW_BASE = 21'h1FE000,
    parameter logic [20:0] SLOW_END  = 21'h1FE800,
    parameter logic [7:0]  MPR_RESET = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_laddr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ready,
    output logic        o_cpu_done,
    output logic [7:0]  o_cpu_rdata,
    input  logic        i_tam_we,
    input  logic [7:0]  i_tam_mask,
    input  logic [7:0]  i_tam_data,
    output logic [7:0]  o_tma_data,
    output logic [20:0] o_addr,
    output logic [7:0]  o_din,
    output logic        o_re,
    output logic        o_we,
    input  logic [7:0]  i_dout
);
    localparam logic [2:0] IDLE = 3'd0, STROBE = 3'd1, DATA = 3'd2, STALL = 3'd3, DONE = 3'd4;
    logic [2:0]  r_state;
    logic [7:0]  r_mpr [8];
    logic        r_wr;
    logic [20:0] w_phys;
    logic        w_slow;
    assign w_phys      = {r_mpr[i_cpu_laddr[15:13]], i_cpu_laddr[12:0]};
    assign w_slow      = SLOW_IO && o_addr >= SLOW_BASE && o_addr < SLOW_END;
    assign o_cpu_ready = r_state == IDLE;
    assign o_cpu_done  = r_state == DONE;
    always_comb begin
        o_tma_data = 8'h00;
        for (int i = 0; i < 8; i++)
            o_tma_data = o_tma_data | (i_tam_mask[i] ? r_mpr[i] : 8'h00);
    end
    // MPR writes use nonblocking updates, so a request accepted on the same edge sees old banks
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_wr        <= 1'b0;
            o_re        <= 1'b0;
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_din       <= '0;
            o_cpu_rdata <= '0;
            for (int i = 0; i < 8; i++) r_mpr[i] <= MPR_RESET;
        end else begin
            if (i_tam_we)
                for (int i = 0; i < 8; i++) if (i_tam_mask[i]) r_mpr[i] <= i_tam_data;
            o_re <= 1'b0;
            o_we <= 1'b0;
            case (r_state)
                IDLE: if (i_cpu_req) begin
                    o_addr  <= w_phys;
                    r_wr    <= i_cpu_we;
                    o_re    <= !i_cpu_we;
                    o_we    <= i_cpu_we;
                    if (i_cpu_we) o_din <= i_cpu_wdata;
                    r_state <= STROBE;
                end
                STROBE: r_state <= DATA;
                DATA: begin
                    if (!r_wr) o_cpu_rdata <= i_dout;
                    r_state <= w_slow ? STALL : DONE;
                end
                STALL:   r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huc6280_bus_master.sv
// tb_huc6280_bus_master: directed checks of translation, strobes, latency, TAM/TMA and reset.
module tb_huc6280_bus_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_laddr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ready, cpu_done;
    logic [7:0]  cpu_rdata;
    logic        tam_we = 1'b0;
    logic [7:0]  tam_mask = '0, tam_data = '0, tma_data;
    logic [20:0] addr;
    logic [7:0]  din, dout = '0;
    logic        re, we;
    int errors = 0, checks = 0;

    huc6280_bus_master dut (
        .i_clk(clk), .i_rst(rst), .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
        .i_cpu_laddr(cpu_laddr), .i_cpu_wdata(cpu_wdata), .o_cpu_ready(cpu_ready),
        .o_cpu_done(cpu_done), .o_cpu_rdata(cpu_rdata), .i_tam_we(tam_we),
        .i_tam_mask(tam_mask), .i_tam_data(tam_data), .o_tma_data(tma_data),
        .o_addr(addr), .o_din(din), .o_re(re), .o_we(we), .i_dout(dout)
    );

    always #5 clk = ~clk;

    // Bus memory: unwritten bytes read as addr[7:0]^addr[15:8]^8'h5A
    logic [7:0] mem [logic [20:0]];
    always @(posedge clk) begin
        if (we) mem[addr] = din;
        if (re) dout <= mem.exists(addr) ? mem[addr] : (addr[7:0] ^ addr[15:8] ^ 8'h5A);
    end

    task automatic tam(input logic [7:0] m, input logic [7:0] d);
        @(negedge clk);
        tam_we = 1'b1; tam_mask = m; tam_data = d;
        @(posedge clk); #1;
        tam_we = 1'b0;
    endtask

    task automatic access(input logic w, input logic [15:0] la, input logic [7:0] wd,
                          input logic tw, input logic [7:0] tm, input logic [7:0] td,
                          output logic [20:0] a, output logic [7:0] di, output logic sre,
                          output logic swe, output int lat, output logic [7:0] rd,
                          output logic wide);
        int t = 0;
        @(negedge clk);
        while (!cpu_ready && t < 20) begin @(negedge clk); t++; end
        cpu_req = 1'b1; cpu_we = w; cpu_laddr = la; cpu_wdata = wd;
        tam_we = tw; tam_mask = tm; tam_data = td;
        @(posedge clk); #1;
        cpu_req = 1'b0; tam_we = 1'b0;
        a = addr; di = din; sre = re; swe = we; lat = 1; wide = 1'b0;
        while (!cpu_done && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (re || we) wide = 1'b1;
        end
        rd = cpu_rdata;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; tam_mask = 8'hFF;
        #1;
        checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cpu_ready); end
        checks++; if ({re, we} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {re, we}); end
        checks++; if (addr !== 21'h0) begin errors++; $display("FAIL reset_addr got %h exp 000000", addr); end
        checks++; if (cpu_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", cpu_done); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", cpu_rdata); end
        checks++; if (tma_data !== 8'h00) begin errors++; $display("FAIL reset_mpr got %h exp 00", tma_data); end
    endtask

    task automatic test_vector_read;
        logic [20:0] a; logic [7:0] di, rd; logic sre, swe, wide; int lat;
        access(1'b0, 16'hFFFE, 8'h00, 1'b0, 8'h00, 8'h00, a, di, sre, swe, lat, rd, wide);
        checks++; if (a !== 21'h001FFE) begin errors++; $display("FAIL vec_addr got %h exp 001ffe", a); end
        checks++; if ({sre, swe} !== 2'b10) begin errors++; $display("FAIL vec_strobe got %b exp 10", {sre, swe}); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL vec_latency got %0d exp 3", lat); end
        checks++; if (rd !== 8'hBB) begin errors++; $display("FAIL vec_rdata got %h exp bb", rd); end
        checks++; if (wide !== 1'b0) begin errors++; $display("FAIL vec_wide got %b exp 0", wide); end
    endtask

    task automatic test_write_readback;
        logic [20:0] a; logic [7:0] di, rd; logic sre, swe, wide; int lat;
        tam(8'h02, 8'hF8);
        tam_mask = 8'h02; #1;
        checks++; if (tma_data !== 8'hF8) begin errors++; $display("FAIL tma_mpr1 got %h exp f8", tma_data); end
        access(1'b1, 16'h2010, 8'hA5, 1'b0, 8'h00, 8'h00, a, di, sre, swe, lat, rd, wide);
        checks++; if (a !== 21'h1F0010) begin errors++; $display("FAIL wr_addr got %h exp 1f0010", a); end
        checks++; if (di !== 8'hA5) begin errors++; $display("FAIL wr_din got %h exp a5", di); end
        checks++; if ({sre, swe} !== 2'b01) begin errors++; $display("FAIL wr_strobe got %b exp 01", {sre, swe}); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
        checks++; if (rd !== 8'hBB) begin errors++; $display("FAIL wr_keeps_rdata got %h exp bb", rd); end
        access(1'b0, 16'h2010, 8'h00, 1'b0, 8'h00, 8'h00, a, di, sre, swe, lat, rd, wide);
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL rd_back got %h exp a5", rd); end
        checks++; if (di !== 8'hA5) begin errors++; $display("FAIL rd_keeps_din got %h exp a5", di); end
    endtask

    task automatic test_slow_window;
        logic [20:0] a; logic [7:0] di, rd; logic sre, swe, wide; int lat;
        tam(8'h01, 8'hFF);
        access(1'b0, 16'h1000, 8'h00, 1'b0, 8'h00, 8'h00, a, di, sre, swe, lat, rd, wide);
        checks++; if (a !== 21'h1FF000) begin errors++; $display("FAIL fast_addr got %h exp 1ff000", a); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL fast_latency got %0d exp 3", lat); end
        checks++; if (rd !== 8'hAA) begin errors++; $display("FAIL fast_rdata got %h exp aa", rd); end
        access(1'b0, 16'h0402, 8'h00, 1'b0, 8'h00, 8'h00, a, di, sre, swe, lat, rd, wide);
        checks++; if (a !== 21'h1FE402) begin errors++; $display("FAIL slow_addr got %h exp 1fe402", a); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL slow_latency got %0d exp 4", lat); end
        checks++; if (rd !== 8'hBC) begin errors++; $display("FAIL slow_rdata got %h exp bc", rd); end
        checks++; if (wide !== 1'b0) begin errors++; $display("FAIL slow_wide got %b exp 0", wide); end
    endtask

    task automatic test_tam_race;
        logic [20:0] a; logic [7:0] di, rd; logic sre, swe, wide; int lat;
        access(1'b0, 16'h1000, 8'h00, 1'b1, 8'h01, 8'h77, a, di, sre, swe, lat, rd, wide);
        checks++; if (a !== 21'h1FF000) begin errors++; $display("FAIL race_old_mpr got %h exp 1ff000", a); end
        tam_mask = 8'h01; #1;
        checks++; if (tma_data !== 8'h77) begin errors++; $display("FAIL race_new_mpr got %h exp 77", tma_data); end
    endtask

    task automatic test_back_to_back;
        int n = 0, first = -1, last = -1;
        logic rdy, prev_re = 1'b0, prev_we = 1'b0, both = 1'b0, wide = 1'b0;
        tam(8'h01, 8'h11);
        tam(8'h02, 8'h22);
        tam(8'h00, 8'hEE);
        tam_mask = 8'h03; #1;
        checks++; if (tma_data !== 8'h33) begin errors++; $display("FAIL tma_or got %h exp 33", tma_data); end
        tam_mask = 8'h00; #1;
        checks++; if (tma_data !== 8'h00) begin errors++; $display("FAIL tma_zero got %h exp 00", tma_data); end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_laddr = 16'h6000;
        for (int c = 0; c < 20; c++) begin
            rdy = cpu_ready;
            @(posedge clk); #1;
            if (rdy) begin n++; if (first < 0) first = c; last = c; end
            if (re && we) both = 1'b1;
            if ((re && prev_re) || (we && prev_we)) wide = 1'b1;
            prev_re = re; prev_we = we;
            @(negedge clk);
        end
        cpu_req = 1'b0;
        repeat (5) @(posedge clk);
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_accepts got %0d exp 5", n); end
        checks++; if (last - first !== 16) begin errors++; $display("FAIL b2b_spacing got %0d exp 16", last - first); end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL b2b_both got %b exp 0", both); end
        checks++; if (wide !== 1'b0) begin errors++; $display("FAIL b2b_wide got %b exp 0", wide); end
    endtask

    task automatic test_reset_mid_access;
        logic seen_done = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_laddr = 16'h2000; cpu_wdata = 8'h3C;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL mid_we_before got %b exp 1", we); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({re, we} !== 2'b00) begin errors++; $display("FAIL mid_strobe_drop got %b exp 00", {re, we}); end
        repeat (4) begin @(posedge clk); #1; if (cpu_done) seen_done = 1'b1; end
        @(negedge clk); rst = 1'b0; tam_mask = 8'hFF;
        repeat (4) begin @(posedge clk); #1; if (cpu_done) seen_done = 1'b1; end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_no_done got %b exp 0", seen_done); end
        checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", cpu_ready); end
        checks++; if (tma_data !== 8'h00) begin errors++; $display("FAIL mid_mpr_reset got %h exp 00", tma_data); end
    endtask

    initial begin
        test_reset;
        test_vector_read;
        test_write_readback;
        test_slow_window;
        test_tam_race;
        test_back_to_back;
        test_reset_mid_access;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
